// File: rtl/fetch_irq_ctrl.sv
// Instruction-fetch PC selection with a vectored, statically prioritised, nestable
// interrupt controller backed by a hardware EPC/level stack.
module fetch_irq_ctrl #(
  parameter int          NUM_IRQ           = 8,
  parameter int          NEST_DEPTH        = 4,
  parameter bit          EDGE_MODE         = 1'b1,
  parameter bit          NESTED            = 1'b1,
  parameter logic [31:0] RESET_ADDRESS     = 32'h0000_0000,
  parameter logic [31:0] EXCEPTION_ADDRESS = 32'h0000_0100,
  parameter logic [31:0] VEC_BASE          = 32'h0000_0200,
  parameter logic [31:0] VEC_STRIDE        = 32'h0000_0010,
  localparam int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
  localparam int DEPTH_W = $clog2(NEST_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [1:0]         pc_sel,
  input  logic [31:0]        pc_branch,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               ie,
  input  logic               rti,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus_4,
  output logic               irq_ack,
  output logic [ID_W-1:0]    irq_id,
  output logic [DEPTH_W-1:0] depth,
  output logic               rti_err
);

  // cur_lvl must also encode NUM_IRQ, the "no handler active" level.
  localparam int LVL_W = $clog2(NUM_IRQ + 1);
  localparam int PTR_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] pend_set;
  logic [NUM_IRQ-1:0] pend_clr;
  logic [LVL_W-1:0]   cur_lvl;
  logic [31:0]        epc_stk [NEST_DEPTH];
  logic [LVL_W-1:0]   lvl_stk [NEST_DEPTH];
  logic [31:0]        npc;
  logic [31:0]        vec_addr;
  logic               cand_vld;
  logic [ID_W-1:0]    cand_idx;
  logic               take;
  logic               do_ret;
  logic               ret_err;
  logic [PTR_W-1:0]   push_ptr;
  logic [PTR_W-1:0]   pop_ptr;

  assign pc_plus_4 = pc + 32'd1;

  always_comb begin
    npc = pc_branch;
    case (pc_sel)
      2'b00:   npc = RESET_ADDRESS;
      2'b01:   npc = EXCEPTION_ADDRESS;
      2'b10:   npc = pc_plus_4;
      default: npc = pc_branch;
    endcase
  end

  // Scan from the top down so the lowest enabled pending index wins.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i] && irq_mask[i]) begin
        cand_vld = 1'b1;
        cand_idx = ID_W'(i);
      end
    end
  end

  assign take = !stall && !rti && ie && cand_vld
                && (depth < DEPTH_W'(NEST_DEPTH))
                && (LVL_W'(cand_idx) < cur_lvl)
                && (NESTED || (depth == '0));

  assign do_ret   = !stall && rti && (depth != '0);
  assign ret_err  = !stall && rti && (depth == '0);
  assign push_ptr = PTR_W'(depth);
  assign pop_ptr  = PTR_W'(depth - DEPTH_W'(1));
  assign vec_addr = VEC_BASE + VEC_STRIDE * 32'(cand_idx);
  assign pend_set = EDGE_MODE ? (irq & ~irq_prev) : irq;
  // Clearing the taken channel overrides a new request arriving in the same cycle.
  assign pend_clr = take ? (NUM_IRQ'(1) << cand_idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_ADDRESS;
      pend     <= '0;
      irq_prev <= '0;
      depth    <= '0;
      cur_lvl  <= LVL_W'(NUM_IRQ);
      irq_ack  <= 1'b0;
      irq_id   <= '0;
      rti_err  <= 1'b0;
    end else begin
      irq_prev <= irq;
      pend     <= (pend | pend_set) & ~pend_clr;
      irq_ack  <= take;
      rti_err  <= ret_err;
      if (take) begin
        pc      <= vec_addr;
        depth   <= depth + DEPTH_W'(1);
        cur_lvl <= LVL_W'(cand_idx);
        irq_id  <= cand_idx;
      end else if (do_ret) begin
        pc      <= epc_stk[pop_ptr];
        cur_lvl <= lvl_stk[pop_ptr];
        depth   <= depth - DEPTH_W'(1);
      end else if (!stall) begin
        pc <= npc;
      end
    end
  end

  // Stack storage carries no reset; only entries below depth are ever read.
  always_ff @(posedge clk) begin
    if (!reset && take) begin
      epc_stk[push_ptr] <= npc;
      lvl_stk[push_ptr] <= cur_lvl;
    end
  end

endmodule

// File: tb/tb_fetch_irq_ctrl.sv
// Bench for fetch_irq_ctrl: two instances (stack depth 4 and 2) share directed stimulus,
// each checked every cycle against its own behavioural model plus literal spot checks.
module tb_fetch_irq_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  pc_sel;
  logic [31:0] pc_branch;
  logic [7:0]  irq;
  logic [7:0]  irq_mask;
  logic        ie;
  logic        rti;

  logic [31:0] pc0, pcp0, pc2, pcp2;
  logic        ack0, err0, ack2, err2;
  logic [2:0]  id0, id2;
  logic [2:0]  depth0;
  logic [1:0]  depth2;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_irq_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel), .pc_branch(pc_branch),
    .irq(irq), .irq_mask(irq_mask), .ie(ie), .rti(rti),
    .pc(pc0), .pc_plus_4(pcp0), .irq_ack(ack0), .irq_id(id0), .depth(depth0),
    .rti_err(err0)
  );

  fetch_irq_ctrl #(.NEST_DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel), .pc_branch(pc_branch),
    .irq(irq), .irq_mask(irq_mask), .ie(ie), .rti(rti),
    .pc(pc2), .pc_plus_4(pcp2), .irq_ack(ack2), .irq_id(id2), .depth(depth2),
    .rti_err(err2)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // behavioural model, one slot per instance
  int          nd [2] = '{4, 2};
  logic [31:0] m_pc [2];
  logic [7:0]  m_pend [2];
  logic [7:0]  m_prev;
  int          m_depth [2];
  int          m_lvl [2];
  logic [31:0] m_stk_pc [2][4];
  int          m_stk_lvl [2][4];
  logic        m_ack [2];
  int          m_id [2];
  logic        m_err [2];
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    logic [31:0] npc;
    logic [7:0]  rise;
    int          cand;
    bit          tk;
    if (reset) m_valid = 1'b1;
    case (pc_sel)
      2'd0:    npc = 32'h0;
      2'd1:    npc = 32'h100;
      2'd2:    npc = m_pc[0];
      default: npc = pc_branch;
    endcase
    rise = irq & ~m_prev;
    for (int k = 0; k < 2; k++) begin
      if (pc_sel == 2'd2) npc = m_pc[k] + 32'd1;
      if (reset) begin
        m_pc[k] = 32'h0; m_pend[k] = 8'h0; m_depth[k] = 0; m_lvl[k] = 8;
        m_ack[k] = 1'b0; m_id[k] = 0; m_err[k] = 1'b0;
      end else begin
        cand = -1;
        for (int i = 7; i >= 0; i--)
          if (m_pend[k][i] && irq_mask[i]) cand = i;
        tk = !stall && !rti && ie && cand >= 0 && m_depth[k] < nd[k] && cand < m_lvl[k];
        m_ack[k] = tk;
        m_err[k] = rti && !stall && m_depth[k] == 0;
        m_pend[k] = m_pend[k] | rise;
        if (tk) begin
          m_stk_pc[k][m_depth[k]]  = npc;
          m_stk_lvl[k][m_depth[k]] = m_lvl[k];
          m_depth[k]++;
          m_lvl[k] = cand;
          m_id[k]  = cand;
          m_pc[k]  = 32'h200 + 32'(cand) * 32'h10;
          m_pend[k][cand] = 1'b0;
        end else if (!stall) begin
          if (rti && m_depth[k] > 0) begin
            m_depth[k]--;
            m_pc[k]  = m_stk_pc[k][m_depth[k]];
            m_lvl[k] = m_stk_lvl[k][m_depth[k]];
          end else begin
            m_pc[k] = npc;
          end
        end
      end
    end
    m_prev = reset ? 8'h0 : irq;
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (m_valid) begin
      check("pc_d4", pc0, m_pc[0]);
      check("pcp4_d4", pcp0, m_pc[0] + 32'd1);
      check("ack_d4", 32'(ack0), 32'(m_ack[0]));
      check("id_d4", 32'(id0), 32'(m_id[0]));
      check("depth_d4", 32'(depth0), 32'(m_depth[0]));
      check("err_d4", 32'(err0), 32'(m_err[0]));
      check("pc_d2", pc2, m_pc[1]);
      check("ack_d2", 32'(ack2), 32'(m_ack[1]));
      check("id_d2", 32'(id2), 32'(m_id[1]));
      check("depth_d2", 32'(depth2), 32'(m_depth[1]));
      check("err_d2", 32'(err2), 32'(m_err[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // directed stimulus with hand-computed spot checks
  initial begin
    reset = 1'b1; stall = 1'b0; pc_sel = 2'd2; pc_branch = 32'h0;
    irq = 8'h00; irq_mask = 8'hFF; ie = 1'b1; rti = 1'b0;
    tick(); tick();
    check("rst_pc", pc0, 32'h0);
    check("rst_depth", 32'(depth0), 32'd0);
    check("rst_ack", 32'(ack0), 32'd0);
    check("rst_id", 32'(id0), 32'd0);
    reset = 1'b0;
    tick(); check("seq_pc1", pc0, 32'h1);
    tick(); check("seq_pc2", pc0, 32'h2);
    tick(); check("seq_pc3", pc0, 32'h3);
    tick();
    irq = 8'h08; tick(); check("pre_irq_pc", pc0, 32'h5);
    irq = 8'h00; tick();
    check("take3_pc", pc0, 32'h230);
    check("take3_ack", 32'(ack0), 32'd1);
    check("take3_id", 32'(id0), 32'd3);
    check("take3_depth", 32'(depth0), 32'd1);
    tick(); check("ack_pulse", 32'(ack0), 32'd0);
    rti = 1'b1; tick(); rti = 1'b0;
    check("rti_pc", pc0, 32'h6);
    check("rti_depth", 32'(depth0), 32'd0);

    // nesting: ch3, pre-empted by ch1, ch5 deferred until final return
    irq = 8'h08; tick(); irq = 8'h00; tick();
    irq = 8'h02; tick(); irq = 8'h00; tick();
    check("nest1_pc", pc0, 32'h210);
    check("nest1_depth", 32'(depth0), 32'd2);
    irq = 8'h20; tick(); irq = 8'h00; tick();
    check("low_pri_pc", pc0, 32'h212);
    check("low_pri_ack", 32'(ack0), 32'd0);
    rti = 1'b1; tick(); check("pop1_pc", pc0, 32'h232);
    tick(); check("pop2_pc", pc0, 32'h8);
    rti = 1'b0; tick();
    check("ch5_pc", pc0, 32'h250);
    check("ch5_ack", 32'(ack0), 32'd1);
    check("ch5_id", 32'(id0), 32'd5);
    rti = 1'b1; tick(); rti = 1'b0;

    // full stack on the depth-2 instance
    irq = 8'h40; tick(); irq = 8'h00; tick();
    irq = 8'h10; tick(); irq = 8'h00; tick();
    check("full_pc_d2", pc2, 32'h240);
    irq = 8'h01; tick(); irq = 8'h00; tick();
    check("full_depth_d2", 32'(depth2), 32'd2);
    check("full_ack_d2", 32'(ack2), 32'd0);
    check("full_pc_d2b", pc2, 32'h242);
    check("deep_pc_d4", pc0, 32'h200);
    check("deep_depth_d4", 32'(depth0), 32'd3);
    tick();
    rti = 1'b1; tick(); rti = 1'b0;
    check("popfull_pc_d2", pc2, 32'h262);
    tick();
    check("ch0_pc_d2", pc2, 32'h200);
    check("ch0_ack_d2", 32'(ack2), 32'd1);
    check("ch0_id_d2", 32'(id2), 32'd0);
    rti = 1'b1; tick(); tick(); rti = 1'b0;
    check("unwind_pc_d4", pc0, 32'hB);
    check("unwind_pc_d2", pc2, 32'hB);

    // masked channel waits until unmasked
    irq_mask = 8'hFB;
    irq = 8'h04; tick(); irq = 8'h00; tick();
    check("masked_ack", 32'(ack0), 32'd0);
    tick(); tick(); tick();
    irq_mask = 8'hFF; tick();
    check("unmask_pc", pc0, 32'h220);
    check("unmask_id", 32'(id0), 32'd2);
    rti = 1'b1; tick(); rti = 1'b0;

    // stall freezes everything but pending capture
    stall = 1'b1; irq = 8'h01; rti = 1'b1; tick();
    check("stall_pc", pc0, 32'h11);
    check("stall_err", 32'(err0), 32'd0);
    check("stall_ack", 32'(ack0), 32'd0);
    irq = 8'h00; tick();
    stall = 1'b0; rti = 1'b0; tick();
    check("post_stall_pc", pc0, 32'h200);
    check("post_stall_ack", 32'(ack0), 32'd1);
    rti = 1'b1; tick();
    check("ret_stall_pc", pc0, 32'h12);
    tick();
    check("rti_err", 32'(err0), 32'd1);
    check("rti_err_pc", pc0, 32'h13);
    rti = 1'b0; tick();
    check("rti_err_clr", 32'(err0), 32'd0);

    // pc_sel sources and wrap
    pc_sel = 2'd3; pc_branch = 32'h1234; tick(); check("branch_pc", pc0, 32'h1234);
    pc_sel = 2'd1; tick(); check("exc_pc", pc0, 32'h100);
    pc_sel = 2'd3; pc_branch = 32'hFFFF_FFFF; tick();
    check("wrap_pcp4", pcp0, 32'h0);
    pc_sel = 2'd2; tick(); check("wrap_pc", pc0, 32'h0);
    pc_sel = 2'd0; tick(); check("sel0_pc", pc0, 32'h0);
    pc_sel = 2'd2;

    // held-high line is a single edge
    irq = 8'h08; tick(); tick(); tick();
    check("edge_once_ack", 32'(ack0), 32'd0);
    irq = 8'h00; rti = 1'b1; tick(); rti = 1'b0;
    check("edge_ret_pc", pc0, 32'h2);

    // reset in a nested handler clears stack and pending
    irq = 8'h08; tick(); irq = 8'h00; tick();
    irq = 8'h02; tick(); irq = 8'h00; tick();
    check("pre_rst_depth", 32'(depth0), 32'd2);
    irq = 8'h20; tick(); irq = 8'h00;
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_rst_pc", pc0, 32'h0);
    check("mid_rst_depth", 32'(depth0), 32'd0);
    tick();
    check("mid_rst_noack", 32'(ack0), 32'd0);
    check("mid_rst_pc1", pc0, 32'h1);
    tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
